branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/branch_cmp.sv | 21 ++
 rtl/branch_resolve.sv | 156 +++++++++++++++
 tb/tb_branch_resolve.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 opcode/funct3 constants and branch-resolve states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;

    localparam logic [2:0] C_F3_BEQ  = 3'b000;
    localparam logic [2:0] C_F3_BNE  = 3'b001;
    localparam logic [2:0] C_F3_BLT  = 3'b100;
    localparam logic [2:0] C_F3_BGE  = 3'b101;
    localparam logic [2:0] C_F3_BLTU = 3'b110;
    localparam logic [2:0] C_F3_BGEU = 3'b111;

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KILL1 = 2'd1,
        ST_KILL2 = 2'd2
    } br_state_e;

endpackage

`default_nettype wire

// File: rtl/branch_cmp.sv
// ============================================================================
// Module      : branch_cmp
// Description : Zero-latency equality / less-than comparator for branches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cmp (
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        BrUn,
    output logic        BrEq,
    output logic        BrLT
);

    assign BrEq = (rs1 == rs2);
    assign BrLT = BrUn ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

endmodule

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
// Module      : branch_resolve
// Description : EX-stage branch/jump resolution with redirect, 2-cycle flush
//               and saturating branch/taken counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_inst,
    input  logic [31:0] ex_pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        BrUn,
    output logic        BrEq,
    output logic        BrLT,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        misalign_err,
    output logic [15:0] br_count,
    output logic [15:0] taken_count
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_i;
    logic [31:0] w_target;
    logic        w_is_branch;
    logic        w_is_jump;
    logic        w_cond_true;
    logic        w_live;
    logic        w_taken;
    logic        w_do_redirect;
    logic        w_do_misalign;

    br_state_e   state_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        flush_q;
    logic        misalign_q;
    logic [15:0] br_count_q;
    logic [15:0] taken_count_q;

    branch_cmp u_cmp (
        .rs1  (rs1_data),
        .rs2  (rs2_data),
        .BrUn (BrUn),
        .BrEq (BrEq),
        .BrLT (BrLT)
    );

    assign w_opcode = ex_inst[6:0];
    assign w_funct3 = ex_inst[14:12];
    assign w_imm_b  = {{19{ex_inst[31]}}, ex_inst[31], ex_inst[7], ex_inst[30:25], ex_inst[11:8], 1'b0};
    assign w_imm_j  = {{11{ex_inst[31]}}, ex_inst[31], ex_inst[19:12], ex_inst[20], ex_inst[30:21], 1'b0};
    assign w_imm_i  = {{20{ex_inst[31]}}, ex_inst[31:20]};

    always_comb begin
        w_is_branch = 1'b0;
        w_is_jump   = 1'b0;
        w_cond_true = 1'b0;
        w_target    = ex_pc + w_imm_b;
        case (w_opcode)
            C_OPC_BRANCH: begin
                // funct3 010/011 are reserved: fall through as not-a-branch
                case (w_funct3)
                    C_F3_BEQ:              begin w_is_branch = 1'b1; w_cond_true = BrEq;  end
                    C_F3_BNE:              begin w_is_branch = 1'b1; w_cond_true = !BrEq; end
                    C_F3_BLT,  C_F3_BLTU:  begin w_is_branch = 1'b1; w_cond_true = BrLT;  end
                    C_F3_BGE,  C_F3_BGEU:  begin w_is_branch = 1'b1; w_cond_true = !BrLT; end
                    default:               w_is_branch = 1'b0;
                endcase
            end
            C_OPC_JAL: begin
                w_is_jump = 1'b1;
                w_target  = ex_pc + w_imm_j;
            end
            C_OPC_JALR: begin
                w_is_jump = 1'b1;
                w_target  = (rs1_data + w_imm_i) & ~32'd1;
            end
            default: w_is_jump = 1'b0;
        endcase
    end

    assign w_live        = ex_valid && (state_q == ST_IDLE);
    assign w_taken       = w_is_jump || (w_is_branch && w_cond_true);
    assign w_do_redirect = w_live && w_taken && !w_target[1];
    assign w_do_misalign = w_live && w_taken &&  w_target[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            flush_q          <= 1'b0;
            misalign_q       <= 1'b0;
            br_count_q       <= 16'd0;
            taken_count_q    <= 16'd0;
        end else begin
            redirect_valid_q <= 1'b0;
            misalign_q       <= 1'b0;

            if (w_live && w_is_branch && (br_count_q != C_CNT_MAX)) begin
                br_count_q <= br_count_q + 16'd1;
            end
            if (w_do_redirect && (taken_count_q != C_CNT_MAX)) begin
                taken_count_q <= taken_count_q + 16'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    flush_q <= 1'b0;
                    if (w_do_redirect) begin
                        state_q          <= ST_KILL1;
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= w_target;
                    end else if (w_do_misalign) begin
                        misalign_q <= 1'b1;
                    end
                end
                ST_KILL1: begin
                    state_q <= ST_KILL2;
                    flush_q <= 1'b1;
                end
                ST_KILL2: begin
                    state_q <= ST_IDLE;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign misalign_err   = misalign_q;
    assign br_count       = br_count_q;
    assign taken_count    = taken_count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// ============================================================================
// Module      : tb_branch_resolve
// Description : Scoreboard bench for branch_resolve.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_inst;
    logic [31:0] ex_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        BrUn;
    logic        BrEq;
    logic        BrLT;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        misalign_err;
    logic [15:0] br_count;
    logic [15:0] taken_count;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_br = 16'd0;
    logic [15:0] exp_tk = 16'd0;

    typedef struct packed {
        logic        rv;
        logic        fl;
        logic        mis;
        logic [31:0] pc;
        logic [15:0] br;
        logic [15:0] tk;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        un;
    } stim_t;

    exp_t  sb[$];
    stim_t stq[$];

    branch_resolve dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_inst        (ex_inst),
        .ex_pc          (ex_pc),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .BrUn           (BrUn),
        .BrEq           (BrEq),
        .BrLT           (BrLT),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .misalign_err   (misalign_err),
        .br_count       (br_count),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    // redirect_pc is only meaningful while redirect_valid is high
    function automatic exp_t mk(input logic rv, input logic fl, input logic mis,
                                input logic [31:0] pc, input logic [15:0] br, input logic [15:0] tk);
        exp_t e;
        e.rv = rv; e.fl = fl; e.mis = mis; e.pc = rv ? pc : 32'd0; e.br = br; e.tk = tk;
        return e;
    endfunction

    function automatic exp_t sample();
        return mk(redirect_valid, flush, misalign_err, redirect_pc, br_count, taken_count);
    endfunction

    function automatic stim_t st(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2, input logic un);
        stim_t s;
        s.v = v; s.inst = inst; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2; s.un = un;
        return s;
    endfunction

    task automatic add(input stim_t s, input exp_t e);
        stq.push_back(s);
        sb.push_back(e);
    endtask

    task automatic bubble(input logic fl);
        add(st(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0), mk(1'b0, fl, 1'b0, 32'd0, exp_br, exp_tk));
    endtask

    task automatic apply(input stim_t s);
        ex_valid = s.v; ex_inst = s.inst; ex_pc = s.pc;
        rs1_data = s.rs1; rs2_data = s.rs2; BrUn = s.un;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t got;
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_inst = 32'd0; ex_pc = 32'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; BrUn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = '{redirect_valid, flush, misalign_err, redirect_pc, br_count, taken_count};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", got);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_compare();
        logic [31:0] a[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1};
        logic [31:0] b[6] = '{32'd1, 32'd1, 32'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd2};
        logic        u[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0]  w[6] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01};
        ex_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rs1_data = a[i]; rs2_data = b[i]; BrUn = u[i];
            #1;
            checks++;
            if ({BrEq, BrLT} !== w[i]) begin
                errors++;
                $display("FAIL cmp[%0d]: {BrEq,BrLT} got %b want %b", i, {BrEq, BrLT}, w[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_blt();
        exp_t got, e;
        exp_br++; exp_tk++;
        add(st(1'b1, enc_b(3'b100, 13'h010), 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0),
            mk(1'b1, 1'b1, 1'b0, 32'h50, exp_br, exp_tk));
        bubble(1'b1);
        bubble(1'b0);
        exp_br++;
        add(st(1'b1, enc_b(3'b110, 13'h010), 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1),
            mk(1'b0, 1'b0, 1'b0, 32'd0, exp_br, exp_tk));
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL blt_bltu: got %h want %h", got, e); end
        end
    endtask

    task automatic test_cond_mix();
        exp_t got, e;
        exp_br++;
        add(st(1'b1, enc_b(3'b101, 13'h010), 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b0),
            mk(1'b0, 1'b0, 1'b0, 32'd0, exp_br, exp_tk));
        exp_br++; exp_tk++;
        add(st(1'b1, enc_b(3'b111, 13'h010), 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b1),
            mk(1'b1, 1'b1, 1'b0, 32'h310, exp_br, exp_tk));
        bubble(1'b1);
        bubble(1'b0);
        exp_br++; exp_tk++;
        add(st(1'b1, enc_b(3'b001, 13'h1FE0), 32'h200, 32'd3, 32'd4, 1'b0),
            mk(1'b1, 1'b1, 1'b0, 32'h1E0, exp_br, exp_tk));
        bubble(1'b1);
        bubble(1'b0);
        exp_br++;
        add(st(1'b1, enc_b(3'b000, 13'h010), 32'h200, 32'd3, 32'd4, 1'b0),
            mk(1'b0, 1'b0, 1'b0, 32'd0, exp_br, exp_tk));
        add(st(1'b1, enc_b(3'b010, 13'h010), 32'h200, 32'd7, 32'd7, 1'b0),
            mk(1'b0, 1'b0, 1'b0, 32'd0, exp_br, exp_tk));
        add(st(1'b1, enc_b(3'b011, 13'h010), 32'h200, 32'd7, 32'd8, 1'b0),
            mk(1'b0, 1'b0, 1'b0, 32'd0, exp_br, exp_tk));
        add(st(1'b0, enc_b(3'b000, 13'h010), 32'h200, 32'd7, 32'd7, 1'b0),
            mk(1'b0, 1'b0, 1'b0, 32'd0, exp_br, exp_tk));
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL cond_mix: got %h want %h", got, e); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, e;
        exp_br++; exp_tk++;
        add(st(1'b1, enc_b(3'b000, 13'h008), 32'h100, 32'h55, 32'h55, 1'b0),
            mk(1'b1, 1'b1, 1'b0, 32'h108, exp_br, exp_tk));
        add(st(1'b1, enc_b(3'b000, 13'h008), 32'h104, 32'h55, 32'h55, 1'b0),
            mk(1'b0, 1'b1, 1'b0, 32'd0, exp_br, exp_tk));
        add(st(1'b1, enc_b(3'b000, 13'h008), 32'h108, 32'h55, 32'h55, 1'b0),
            mk(1'b0, 1'b0, 1'b0, 32'd0, exp_br, exp_tk));
        bubble(1'b0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL back_to_back: got %h want %h", got, e); end
        end
    endtask

    task automatic test_jumps();
        exp_t got, e;
        exp_tk++;
        add(st(1'b1, enc_jal(21'h1FFFF8), 32'h1000, 32'd0, 32'd0, 1'b0),
            mk(1'b1, 1'b1, 1'b0, 32'hFF8, exp_br, exp_tk));
        bubble(1'b1);
        bubble(1'b0);
        exp_tk++;
        add(st(1'b1, enc_jalr(12'h100), 32'h80, 32'h301, 32'd0, 1'b0),
            mk(1'b1, 1'b1, 1'b0, 32'h400, exp_br, exp_tk));
        bubble(1'b1);
        bubble(1'b0);
        add(st(1'b1, enc_jalr(12'h000), 32'h80, 32'h203, 32'd0, 1'b0),
            mk(1'b0, 1'b0, 1'b1, 32'd0, exp_br, exp_tk));
        bubble(1'b0);
        exp_br++;
        add(st(1'b1, enc_b(3'b000, 13'h006), 32'h100, 32'h9, 32'h9, 1'b0),
            mk(1'b0, 1'b0, 1'b1, 32'd0, exp_br, exp_tk));
        bubble(1'b0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL jumps_misalign: got %h want %h", got, e); end
        end
    endtask

    task automatic test_saturate();
        exp_t got, e;
        force dut.taken_count_q = 16'hFFFF;
        apply(st(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0));
        release dut.taken_count_q;
        exp_tk = 16'hFFFF;
        add(st(1'b1, enc_jal(21'h000010), 32'h2000, 32'd0, 32'd0, 1'b0),
            mk(1'b1, 1'b1, 1'b0, 32'h2010, exp_br, exp_tk));
        bubble(1'b1);
        bubble(1'b0);
        add(st(1'b1, enc_jal(21'h000020), 32'h3000, 32'd0, 32'd0, 1'b0),
            mk(1'b1, 1'b1, 1'b0, 32'h3020, exp_br, exp_tk));
        bubble(1'b1);
        bubble(1'b0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL saturate: got %h want %h", got, e); end
        end
    endtask

    task automatic test_reset_mid_kill();
        exp_t got, e;
        logic [36:0] rs_obs;
        exp_br++;
        if (exp_tk != 16'hFFFF) exp_tk++;
        apply(st(1'b1, enc_b(3'b000, 13'h020), 32'h500, 32'h1, 32'h1, 1'b0));
        got = sample(); e = mk(1'b1, 1'b1, 1'b0, 32'h520, exp_br, exp_tk); checks++;
        if (got !== e) begin errors++; $display("FAIL midkill_pre: got %h want %h", got, e); end
        #2;
        rst_n = 1'b0;
        #1;
        rs_obs = {dut.state_q, flush, redirect_valid, misalign_err, br_count, taken_count};
        checks++;
        if (rs_obs !== {ST_IDLE, 35'd0}) begin
            errors++;
            $display("FAIL midkill_reset: got %h want %h", rs_obs, {ST_IDLE, 35'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_br = 16'd1; exp_tk = 16'd0;
        add(st(1'b1, enc_b(3'b001, 13'h040), 32'h600, 32'hAA, 32'hAA, 1'b0),
            mk(1'b0, 1'b0, 1'b0, 32'd0, exp_br, exp_tk));
        bubble(1'b0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL midkill_post: got %h want %h", got, e); end
        end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_blt();
        test_cond_mix();
        test_back_to_back();
        test_jumps();
        test_saturate();
        test_reset_mid_kill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
